// File: rtl/seq_div_pkg.sv
// Shared types and sizing for the sequential signed divider.
// Latency WIDTH+1 cycles from start to ready; start while busy aborts and reloads.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/seq_signed_divider_if.sv
// Operand/result bundle of the divider; master drives operands, slave returns results.
// Single start pulse per division, no backpressure: ready only reports idle/valid.
interface seq_signed_divider_if #(
  parameter int WIDTH = seq_div_pkg::DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             ready;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, A, B,
    input  Quotient, Remainder, ready, div_by_zero, overflow
  );

  modport slave (
    input  start, A, B,
    output Quotient, Remainder, ready, div_by_zero, overflow
  );

endinterface

// File: rtl/div_restoring_step.sv
// One radix-2 restoring division step on magnitudes: shift, trial subtract, restore.
// Purely combinational; zero latency, no flow control.
module div_restoring_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH+1:0] trial;

  always_comb begin
    // Partial remainder stays below |B| <= 2^(WIDTH-1), so the MSB of trial is a true sign.
    trial   = {rem_in, quo_in[WIDTH-1]} - {1'b0, divisor};
    rem_out = trial[WIDTH+1] ? {rem_in[WIDTH-1:0], quo_in[WIDTH-1]} : trial[WIDTH:0];
    quo_out = {quo_in[WIDTH-2:0], ~trial[WIDTH+1]};
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: magnitudes through WIDTH restoring steps, then sign fix.
// Latency WIDTH+1 edges from start to ready; start while busy aborts and restarts.
module seq_signed_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_signed_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   divisor_q, divisor_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             sign_quo_q, sign_quo_d;
  logic             sign_rem_q, sign_rem_d;
  logic             b_zero_q, b_zero_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   abs_b;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  div_restoring_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (divisor_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      divisor_q     <= '0;
      a_q           <= '0;
      sign_quo_q    <= 1'b0;
      sign_rem_q    <= 1'b0;
      b_zero_q      <= 1'b0;
      ovf_pend_q    <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      divisor_q     <= divisor_d;
      a_q           <= a_d;
      sign_quo_q    <= sign_quo_d;
      sign_rem_q    <= sign_rem_d;
      b_zero_q      <= b_zero_d;
      ovf_pend_q    <= ovf_pend_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = ITER;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ITER:    state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : ITER;
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ready       = (state_q == IDLE);
    bus.Quotient    = quotient_q;
    bus.Remainder   = remainder_q;
    bus.div_by_zero = div_by_zero_q;
    bus.overflow    = overflow_q;
  end

  always_comb begin
    // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits WIDTH bits when read as unsigned.
    abs_a = bus.A[WIDTH-1] ? -bus.A : bus.A;
    b_ext = {bus.B[WIDTH-1], bus.B};
    abs_b = bus.B[WIDTH-1] ? -b_ext : b_ext;

    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    divisor_d     = divisor_q;
    a_d           = a_q;
    sign_quo_d    = sign_quo_q;
    sign_rem_d    = sign_rem_q;
    b_zero_d      = b_zero_q;
    ovf_pend_d    = ovf_pend_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;

    if (bus.start) begin
      // A restart from any state discards in-flight work; published results are untouched.
      cnt_d         = '0;
      rem_d         = '0;
      quo_d         = abs_a;
      divisor_d     = abs_b;
      a_d           = bus.A;
      sign_quo_d    = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
      sign_rem_d    = bus.A[WIDTH-1];
      b_zero_d      = (bus.B == '0);
      ovf_pend_d    = (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.B == '1);
      div_by_zero_d = 1'b0;
      overflow_d    = 1'b0;
    end else begin
      case (state_q)
        ITER: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CW'(1);
        end
        FIX: begin
          if (b_zero_q) begin
            quotient_d  = '1;
            remainder_d = a_q;
          end else begin
            quotient_d  = sign_quo_q ? -quo_q : quo_q;
            remainder_d = sign_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          end
          div_by_zero_d = b_zero_q;
          overflow_d    = ovf_pend_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider (WIDTH=8) with hand-computed expectations.
module tb_seq_signed_divider;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  seq_signed_divider_if #(.WIDTH(8)) bus ();

  seq_signed_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start for one edge, then counts edges until ready (0 = never dropped, -1 = timeout).
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = -1;
    if (bus.ready) begin
      lat = 0;
    end else begin
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk);
        #1;
        if (bus.ready) begin
          lat = i;
          break;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = 8'h00;
    bus.B     = 8'h00;
    #12;
    total++;
    if ({bus.ready, bus.Quotient, bus.Remainder, bus.div_by_zero, bus.overflow} !== {1'b1, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got ready=%b Q=%h R=%h dbz=%b ovf=%b, want ready=1 Q=00 R=00 dbz=0 ovf=0",
               bus.ready, bus.Quotient, bus.Remainder, bus.div_by_zero, bus.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    run_div(8'd100, 8'd7, lat);
    total++;
    if (lat !== 9) begin
      bad++;
      $display("FAIL basic_latency: got %0d edges, want 9", lat);
    end
    total++;
    if ({bus.Quotient, bus.Remainder, bus.div_by_zero, bus.overflow} !== {8'h0E, 8'h02, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL basic_100_7: got Q=%h R=%h dbz=%b ovf=%b, want Q=0e R=02 dbz=0 ovf=0",
               bus.Quotient, bus.Remainder, bus.div_by_zero, bus.overflow);
    end
  endtask

  task automatic test_signs;
    int lat;
    run_div(8'h9C, 8'd7, lat);
    total++;
    if ({bus.Quotient, bus.Remainder} !== {8'hF2, 8'hFE} || lat !== 9) begin
      bad++;
      $display("FAIL signs_m100_7: got Q=%h R=%h lat=%0d, want Q=f2 R=fe lat=9", bus.Quotient, bus.Remainder, lat);
    end
    run_div(8'd100, 8'hF9, lat);
    total++;
    if ({bus.Quotient, bus.Remainder} !== {8'hF2, 8'h02}) begin
      bad++;
      $display("FAIL signs_100_m7: got Q=%h R=%h, want Q=f2 R=02", bus.Quotient, bus.Remainder);
    end
    run_div(8'hEC, 8'hFB, lat);
    total++;
    if ({bus.Quotient, bus.Remainder} !== {8'h04, 8'h00}) begin
      bad++;
      $display("FAIL signs_m20_m5: got Q=%h R=%h, want Q=04 R=00", bus.Quotient, bus.Remainder);
    end
  endtask

  task automatic test_overflow;
    int lat;
    run_div(8'h80, 8'hFF, lat);
    total++;
    if ({bus.Quotient, bus.Remainder, bus.overflow, bus.div_by_zero} !== {8'h80, 8'h00, 1'b1, 1'b0} || lat !== 9) begin
      bad++;
      $display("FAIL overflow_m128_m1: got Q=%h R=%h ovf=%b dbz=%b lat=%0d, want Q=80 R=00 ovf=1 dbz=0 lat=9",
               bus.Quotient, bus.Remainder, bus.overflow, bus.div_by_zero, lat);
    end
    run_div(8'h80, 8'h01, lat);
    total++;
    if ({bus.Quotient, bus.Remainder, bus.overflow} !== {8'h80, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL overflow_m128_1: got Q=%h R=%h ovf=%b, want Q=80 R=00 ovf=0", bus.Quotient, bus.Remainder, bus.overflow);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    run_div(8'd5, 8'd0, lat);
    total++;
    if (lat !== 9) begin
      bad++;
      $display("FAIL divzero_latency: got %0d edges, want 9", lat);
    end
    total++;
    if ({bus.Quotient, bus.Remainder, bus.div_by_zero, bus.overflow} !== {8'hFF, 8'h05, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL divzero_5_0: got Q=%h R=%h dbz=%b ovf=%b, want Q=ff R=05 dbz=1 ovf=0",
               bus.Quotient, bus.Remainder, bus.div_by_zero, bus.overflow);
    end
    run_div(8'd100, 8'd7, lat);
    total++;
    if ({bus.Quotient, bus.Remainder, bus.div_by_zero} !== {8'h0E, 8'h02, 1'b0}) begin
      bad++;
      $display("FAIL divzero_clear: got Q=%h R=%h dbz=%b, want Q=0e R=02 dbz=0", bus.Quotient, bus.Remainder, bus.div_by_zero);
    end
  endtask

  task automatic test_abort;
    int lat;
    int early;
    early = 0;
    @(negedge clk);
    bus.A     = 8'd50;
    bus.B     = 8'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready) early++;
    end
    // Third edge after start passes, then the re-pulse lands on the fourth.
    run_div(8'd9, 8'd2, lat);
    total++;
    if (lat !== 9 || early !== 0) begin
      bad++;
      $display("FAIL abort_latency: got %0d edges after re-pulse (early ready %0d), want 9 (0)", lat, early);
    end
    total++;
    if ({bus.Quotient, bus.Remainder} !== {8'h04, 8'h01}) begin
      bad++;
      $display("FAIL abort_9_2: got Q=%h R=%h, want Q=04 R=01", bus.Quotient, bus.Remainder);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    bus.A     = 8'd77;
    bus.B     = 8'd10;
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.ready !== 1'b0) begin
      bad++;
      $display("FAIL held_start_busy: got ready=%b, want 0", bus.ready);
    end
    run_div(8'hB3, 8'd10, lat);
    total++;
    if ({bus.Quotient, bus.Remainder} !== {8'hF9, 8'hF9} || lat !== 9) begin
      bad++;
      $display("FAIL held_start_m77_10: got Q=%h R=%h lat=%0d, want Q=f9 R=f9 lat=9", bus.Quotient, bus.Remainder, lat);
    end
  endtask

  task automatic test_async_reset;
    int lat;
    @(negedge clk);
    bus.A     = 8'd100;
    bus.B     = 8'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.ready, bus.Quotient, bus.Remainder, bus.div_by_zero, bus.overflow} !== {1'b1, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: got ready=%b Q=%h R=%h dbz=%b ovf=%b, want ready=1 Q=00 R=00 dbz=0 ovf=0",
               bus.ready, bus.Quotient, bus.Remainder, bus.div_by_zero, bus.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_div(8'd20, 8'hFA, lat);
    total++;
    if ({bus.Quotient, bus.Remainder} !== {8'hFD, 8'h02} || lat !== 9) begin
      bad++;
      $display("FAIL after_reset_20_m6: got Q=%h R=%h lat=%0d, want Q=fd R=02 lat=9", bus.Quotient, bus.Remainder, lat);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_div_zero();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
